// File: rtl/lamp_seq_gen.sv
// Programmable lamp-sequence generator: plays one-hot lamp step lists followed
// by all-off gaps, a configurable number of times, with registered outputs.
module lamp_seq_gen #(
  parameter int DWELL_W = 4,
  parameter int REP_W   = 3,
  parameter int GAP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [REP_W-1:0]   repeat_cnt,
  output logic               lamp1,
  output logic               lamp2,
  output logic               lamp3,
  output logic               busy,
  output logic               done,
  output logic [REP_W-1:0]   seq_count
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAPS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] M_NORMAL  = 2'd0;
  localparam logic [1:0] M_SKIP    = 2'd1;
  localparam logic [1:0] M_REVERSE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         mode_q;
  logic [DWELL_W-1:0] d_last;
  logic [REP_W-1:0]   r_q;
  logic [2:0]         step;
  logic [DWELL_W-1:0] dcnt;
  logic [GAP_W-1:0]   gcnt;
  logic [2:0]         lamps;   // {lamp3, lamp2, lamp1}

  function automatic logic [2:0] last_step(input logic [1:0] m);
    case (m)
      M_NORMAL, M_REVERSE: last_step = 3'd2;
      M_SKIP:              last_step = 3'd1;
      default:             last_step = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] step_lamps(input logic [1:0] m, input logic [2:0] s);
    step_lamps = 3'b000;
    case (m)
      M_NORMAL:  step_lamps = (s == 3'd0) ? 3'b001 : (s == 3'd1) ? 3'b010 : 3'b100;
      M_SKIP:    step_lamps = (s == 3'd0) ? 3'b001 : 3'b100;
      M_REVERSE: step_lamps = (s == 3'd0) ? 3'b100 : (s == 3'd1) ? 3'b010 : 3'b001;
      default:   step_lamps = (s == 3'd4) ? 3'b100 : s[0] ? 3'b010 : 3'b001;
    endcase
  endfunction

  assign lamp1 = lamps[0];
  assign lamp2 = lamps[1];
  assign lamp3 = lamps[2];

  // Outputs are computed from the next state so they stay purely registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      d_last    <= '0;
      r_q       <= '0;
      step      <= '0;
      dcnt      <= '0;
      gcnt      <= '0;
      lamps     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            mode_q    <= mode;
            d_last    <= (dwell == '0) ? '0 : dwell - 1'b1;
            r_q       <= (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
            seq_count <= '0;
            step      <= '0;
            dcnt      <= '0;
            state     <= S_RUN;
            busy      <= 1'b1;
            lamps     <= step_lamps(mode, 3'd0);
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            lamps <= '0;
            busy  <= 1'b0;
          end else if (dcnt == d_last) begin
            dcnt <= '0;
            if (step == last_step(mode_q)) begin
              state     <= S_GAPS;
              gcnt      <= '0;
              lamps     <= '0;
              seq_count <= seq_count + 1'b1;
            end else begin
              step  <= step + 3'd1;
              lamps <= step_lamps(mode_q, step + 3'd1);
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_GAPS: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (gcnt == GAP_W'(GAP - 1)) begin
            gcnt <= '0;
            if (seq_count == r_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_RUN;
              step  <= '0;
              lamps <= step_lamps(mode_q, 3'd0);
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_seq_gen.sv
// Bench for lamp_seq_gen: directed scenarios plus random traffic, checked
// cycle by cycle against a trace-building reference model.
module tb_lamp_seq_gen;
  localparam int DWELL_W = 4;
  localparam int REP_W   = 3;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [REP_W-1:0] repeat_cnt = '0;
  logic lamp1, lamp2, lamp3, busy, done;
  logic [REP_W-1:0] seq_count;

  lamp_seq_gen #(.DWELL_W(DWELL_W), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .dwell(dwell), .repeat_cnt(repeat_cnt), .lamp1(lamp1), .lamp2(lamp2),
    .lamp3(lamp3), .busy(busy), .done(done), .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output word: {lamp3,lamp2,lamp1, busy, done, seq_count}
  function automatic int pk(int lamp, int b, int d, int sc);
    int l;
    l = (lamp == 0) ? 0 : (1 << (lamp - 1));
    return (l << (REP_W + 2)) | (b << (REP_W + 1)) | (d << REP_W) | sc;
  endfunction

  int exp_q[$];
  int cur = 0;

  // Full expected trace of one run, from the cycle after start through done.
  task automatic build_run(input int m, input int dw, input int rp);
    int steps[$];
    int d, r;
    case (m)
      0: steps = '{1, 2, 3};
      1: steps = '{1, 3};
      2: steps = '{3, 2, 1};
      default: steps = '{1, 2, 1, 2, 3};
    endcase
    d = (dw == 0) ? 1 : dw;
    r = (rp == 0) ? 1 : rp;
    exp_q.delete();
    for (int s = 0; s < r; s++) begin
      foreach (steps[i])
        for (int c = 0; c < d; c++) exp_q.push_back(pk(steps[i], 1, 0, s));
      for (int g = 0; g < GAP; g++) exp_q.push_back(pk(0, 1, 0, s + 1));
    end
    exp_q.push_back(pk(0, 0, 1, r));
  endtask

  function automatic int sc_of(int w);  return w & ((1 << REP_W) - 1); endfunction
  function automatic int busy_of(int w); return (w >> (REP_W + 1)) & 1; endfunction
  function automatic int done_of(int w); return (w >> REP_W) & 1; endfunction

  int alarms = 0;
  int det_stage = 0;   // simple downstream detector: L1 then L2 then L3 alarms
  int prev_lamp = 0;

  task automatic cyc(input bit st, input bit ab, input int m, input int dw,
                     input int rp, input bit rs);
    int got, lampn;
    start = st; abort = ab; mode = 2'(m); dwell = DWELL_W'(dw);
    repeat_cnt = REP_W'(rp); reset = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q.delete(); cur = pk(0, 0, 0, 0);
    end else if (busy_of(cur) == 1 && ab) begin
      exp_q.delete(); cur = pk(0, 0, 0, sc_of(cur));
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (done_of(cur) == 0 && st && !ab) begin
      build_run(m, dw, rp); cur = exp_q.pop_front();
    end else begin
      cur = pk(0, 0, 0, sc_of(cur));
    end
    got = pk(0, 0, 0, 0) | ({lamp3, lamp2, lamp1} << (REP_W + 2)) |
          (int'(busy) << (REP_W + 1)) | (int'(done) << REP_W) | int'(seq_count);
    chk("outputs", got, cur);
    chk("onehot", int'($countones({lamp3, lamp2, lamp1}) <= 1), 1);
    lampn = lamp1 ? 1 : lamp2 ? 2 : lamp3 ? 3 : 0;
    if (lampn != prev_lamp && lampn != 0) begin
      if (lampn == 1) det_stage = 1;
      else if (lampn == 2 && det_stage == 1) det_stage = 2;
      else if (lampn == 3 && det_stage == 2) begin alarms++; det_stage = 0; end
      else det_stage = 0;
    end else if (lampn == 0 && prev_lamp != 0) det_stage = 0;
    prev_lamp = lampn;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int a0;
    // reset state
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 1);   // start under reset is ignored
    idle_n(2);

    // NORMAL dwell=1 rep=1: one alarm, done in cycle 6
    a0 = alarms;
    cyc(1, 0, 0, 1, 1, 0);
    idle_n(7);
    chk("normal_alarm", alarms - a0, 1);
    chk("normal_sc", int'(seq_count), 1);

    // SKIP dwell=3 rep=2: never alarms
    a0 = alarms;
    cyc(1, 0, 1, 3, 2, 0);
    idle_n(19);
    chk("skip_alarm", alarms - a0, 0);
    chk("skip_sc", int'(seq_count), 2);

    // STUTTER dwell=0 rep=1: alarms once
    a0 = alarms;
    cyc(1, 0, 3, 0, 1, 0);
    idle_n(9);
    chk("stutter_alarm", alarms - a0, 1);

    // REVERSE: no alarm
    a0 = alarms;
    cyc(1, 0, 2, 0, 1, 0);
    idle_n(7);
    chk("reverse_alarm", alarms - a0, 0);

    // abort in cycle 14 of NORMAL dwell=4 rep=3, restart in cycle 16
    cyc(1, 0, 0, 4, 3, 0);
    idle_n(13);
    cyc(0, 1, 0, 0, 0, 0);
    chk("abort_sc", int'(seq_count), 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    chk("restart_l1", int'(lamp1), 1);
    chk("restart_sc", int'(seq_count), 0);
    idle_n(8);

    // start pulses while busy and in DONE cycle, config changes mid-run
    cyc(1, 0, 0, 2, 1, 0);           // 1..8 busy, done in 9
    cyc(0, 0, 2, 5, 7, 0);
    cyc(1, 0, 1, 1, 1, 0);
    idle_n(2);
    cyc(1, 0, 3, 3, 3, 0);
    idle_n(3);
    cyc(1, 0, 1, 1, 1, 0);           // DONE cycle start ignored
    chk("done_start_ignored_busy", int'(busy), 0);
    idle_n(3);

    // reset mid-run
    cyc(1, 0, 0, 2, 2, 0);
    idle_n(2);
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset_busy", int'(busy), 0);
    idle_n(2);

    // abort wins over start in IDLE
    cyc(1, 1, 0, 1, 1, 0);
    chk("abort_over_start", int'(busy), 0);
    idle_n(1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 7)), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lamp_seq_gen.md
# lamp_seq_gen

Programmable lamp-sequence generator: drives the three lamp lines with a one-hot pattern (lamp1/lamp2/lamp3 steps separated by all-off gaps), played a configurable number of times. It is the stimulus end of the lamp-alarm interface. It feeds the lamp sequence detector on the board, or its bench, and produces both alarming (1→2→3) and non-alarming sequences on command.

## Interface
- DWELL_W, 4, width of the per-step dwell setting
- REP_W, 3, width of the repeat setting and of seq_count
- GAP, 2, all-off cycles appended after every sequence (≥1)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  reset, synchronous, active-high
- start  input  1  request a run; sampled only in IDLE
- abort  input  1  terminate a run immediately; no done pulse
- mode  input  2  sequence select: 00 NORMAL, 01 SKIP, 10 REVERSE, 11 STUTTER
- dwell  input  DWELL_W  cycles each step is held; 0 treated as 1
- repeat_cnt  input  REP_W  sequences per run; 0 treated as 1
- lamp1, lamp2, lamp3  output  1 each  lamp drives; at most one high in any cycle
- busy  output  1  run in progress (steps or gaps)
- done  output  1  one-cycle pulse at normal run completion
- seq_count  output  REP_W  sequences completed in current/last run

## Operation
- Step lists: NORMAL L1,L2,L3 (S=3). SKIP L1,L3 (S=2). REVERSE L3,L2,L1 (S=3). STUTTER L1,L2,L1,L2,L3 (S=5).
- With a correct detector downstream, NORMAL and STUTTER alarm once per sequence. SKIP and REVERSE never alarm.
- States: IDLE, RUN, GAPS, DONE. A step index (0..S-1), a dwell counter, a gap counter and a repeat counter are kept.
- IDLE: lamps off, busy=0. If start=1 and abort=0, latch mode, D=max(dwell,1) and R=max(repeat_cnt,1), clear seq_count, step=0, go to RUN.
- RUN: drive the lamp of the current step. After D cycles on a step, advance the step. After the last step's D cycles, go to GAPS and increment seq_count.
- GAPS: lamps off for exactly GAP cycles. Then, if seq_count==R, go to DONE. Otherwise step=0 and go to RUN.
- DONE: one cycle. done=1, busy=0, lamps off. Then IDLE.
- abort=1 in RUN or GAPS: next cycle IDLE, lamps off, busy=0, no done. seq_count holds its value.
- abort in IDLE or DONE has no effect. abort wins over start in the same cycle.
- start is ignored outside IDLE, including the DONE cycle. Config inputs are ignored after latching.
- reset: state IDLE, lamp1=lamp2=lamp3=0, busy=0, done=0, seq_count=0, all counters 0. Reset overrides start and abort, including mid-run.
- Widths: dwell counter DWELL_W bits. The repeat comparison uses REP_W bits; R≤2^REP_W−1, so seq_count never wraps.

## Timing
- start sampled high in cycle k (in IDLE): first step lamp and busy high in cycle k+1.
- All outputs are registered, with no combinational path from inputs to outputs.
- Run length: busy high for exactly R·(S·D+GAP) cycles, from k+1 through k+R·(S·D+GAP). done high in the following cycle only.
- Step boundaries: a lamp drops and the next rises on the same edge, with no all-off cycle between steps of one sequence.
- seq_count updates on the edge entering GAPS.
- abort sampled high in cycle j: lamps and busy low from cycle j+1.
- Earliest restart: start accepted in the cycle after DONE.

## Test plan
- NORMAL, dwell=1, rep=1, start at cycle 0:
  - lamp1 in cycle 1, lamp2 in cycle 2, lamp3 in cycle 3.
  - All off in cycles 4–5, busy high in cycles 1–5.
  - done=1 in cycle 6 only, seq_count=1.
  - Downstream detector alarm once.
- SKIP, dwell=3, rep=2:
  - lamp1 for 3 cycles, lamp3 for 3 cycles, 2 off cycles, all twice.
  - busy high for 16 cycles, done in cycle 17, seq_count=2.
  - Detector never alarms.
- STUTTER, dwell=0 (treated as 1), rep=1:
  - Lamps L1,L2,L1,L2,L3 in cycles 1–5.
  - done in cycle 8, detector alarms exactly once.
  - Repeat with REVERSE: done in cycle 6, no alarm.
- Abort:
  - NORMAL, dwell=4, rep=3, abort in cycle 14: all outputs low from cycle 15.
  - No done pulse, seq_count=1.
  - start in cycle 16 begins a new run with lamp1 in cycle 17 and seq_count=0.
- Start while busy:
  - start pulses in cycles 2 and 5 and in the DONE cycle are ignored.
  - Changing mode/dwell mid-run does not alter the pattern.
- Reset mid-run:
  - reset in cycle 3 of a NORMAL run: cycle 4 has all outputs 0 and state IDLE.
  - start with reset=1 is ignored.
